// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port with
// same-cycle bypass, and a bulk-clear sweep engine. Option: REGFILE_R0_ZERO_EN.
//
// state | meaning
// IDLE  | normal read/write/bypass, waiting for clear
// SWEEP | zeroing one entry per cycle, writes and clear requests ignored
module regfile_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              RFWrite,
  input  logic [ADDR_W-1:0] regW,
  input  logic [DATA_W-1:0] dataW,
  input  logic [ADDR_W-1:0] regA,
  input  logic [ADDR_W-1:0] regB,
  input  logic              clear,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic              busy,
  output logic              clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              byp_ok;
  logic              wr_addr_ok;

`ifdef REGFILE_R0_ZERO_EN
  assign wr_addr_ok = (regW != '0);
`else
  assign wr_addr_ok = 1'b1;
`endif

  // A clear request wins over a write issued in the same cycle.
  assign wr_en  = (state == IDLE) && RFWrite && !clear && wr_addr_ok;
  assign byp_ok = (state == IDLE) && RFWrite;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == SWEEP) begin
        cnt <= cnt + 1'b1;
      end else if (clear) begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear) state_nxt = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (&cnt) begin
          clear_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      mem[regW] <= dataW;
    end
  end

  always_comb begin
    dataA = mem[regA];
    dataB = mem[regB];
    if (byp_ok && (regW == regA)) dataA = dataW;
    if (byp_ok && (regW == regB)) dataB = dataW;
`ifdef REGFILE_R0_ZERO_EN
    if (regA == '0) dataA = '0;
    if (regB == '0) dataB = '0;
`endif
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: stimulus queues expected output values,
// a negedge monitor pops and compares them. Covers default and 16x8 instances.
module tb_regfile_param;

  localparam int SA = 0, SB = 1, SBUSY = 2, SDONE = 3;
  localparam int WA = 4, WB = 5, WBUSY = 6, WDONE = 7;

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic        CLOCK_50 = 1'b0;
  logic        resetn;

  logic        RFWrite, clear, busy, clear_done;
  logic [1:0]  regW, regA, regB;
  logic [7:0]  dataW, dataA, dataB;

  logic        w_RFWrite, w_clear, w_busy, w_clear_done;
  logic [2:0]  w_regW, w_regA, w_regB;
  logic [15:0] w_dataW, w_dataA, w_dataB;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  regfile_param u_dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .RFWrite   (RFWrite),
    .regW      (regW),
    .dataW     (dataW),
    .regA      (regA),
    .regB      (regB),
    .clear     (clear),
    .dataA     (dataA),
    .dataB     (dataB),
    .busy      (busy),
    .clear_done(clear_done)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3)) u_dut_w (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .RFWrite   (w_RFWrite),
    .regW      (w_regW),
    .dataW     (w_dataW),
    .regA      (w_regA),
    .regB      (w_regB),
    .clear     (w_clear),
    .dataA     (w_dataA),
    .dataB     (w_dataB),
    .busy      (w_busy),
    .clear_done(w_clear_done)
  );

  function automatic logic [31:0] actual(int sig);
    case (sig)
      SA:      return 32'(dataA);
      SB:      return 32'(dataB);
      SBUSY:   return 32'(busy);
      SDONE:   return 32'(clear_done);
      WA:      return 32'(w_dataA);
      WB:      return 32'(w_dataB);
      WBUSY:   return 32'(w_busy);
      default: return 32'(w_clear_done);
    endcase
  endfunction

  always @(negedge CLOCK_50) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = q.pop_front();
      act = actual(e.sig);
      n_checks++;
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
    end
  end

  task automatic expect_v(input string name, input int sig, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    RFWrite = 1'b1; regW = a; dataW = d;
    cyc();
    RFWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    RFWrite = 1'b0; clear = 1'b0; regW = '0; regA = '0; regB = '0; dataW = '0;
    w_RFWrite = 1'b0; w_clear = 1'b0; w_regW = '0; w_regA = '0; w_regB = '0; w_dataW = '0;

    // reset state
    cyc();
    regA = 2'd2; regB = 2'd3;
    expect_v("rst_dataA", SA, 0);
    expect_v("rst_dataB", SB, 0);
    expect_v("rst_busy", SBUSY, 0);
    expect_v("rst_done", SDONE, 0);
    expect_v("rst_w_busy", WBUSY, 0);
    cyc();
    resetn = 1'b1;

    // basic write/read
    cyc();
    wr(2'd2, 8'hA5);
    wr(2'd1, 8'h3C);
    regA = 2'd2; regB = 2'd1;
    expect_v("rd_r2", SA, 8'hA5);
    expect_v("rd_r1", SB, 8'h3C);
    cyc();
    regA = 2'd0; regB = 2'd3;
    expect_v("rd_r0_zero", SA, 0);
    expect_v("rd_r3_zero", SB, 0);

    // bypass
    cyc();
    wr(2'd3, 8'h11);
    regA = 2'd3; regB = 2'd3;
    expect_v("r3_stored", SA, 8'h11);
    cyc();
    RFWrite = 1'b1; regW = 2'd3; dataW = 8'h77;
    expect_v("byp_A", SA, 8'h77);
    expect_v("byp_B", SB, 8'h77);
    cyc();
    RFWrite = 1'b0; dataW = 8'h00;
    expect_v("after_byp_A", SA, 8'h77);
    expect_v("after_byp_B", SB, 8'h77);

    // sweep
    cyc();
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h02);
    wr(2'd2, 8'h03);
    wr(2'd3, 8'h04);
    clear = 1'b1; regA = 2'd0; regB = 2'd3;
`ifdef REGFILE_R0_ZERO_EN
    expect_v("pre_sweep_r0", SA, 8'h00);
`else
    expect_v("pre_sweep_r0", SA, 8'h01);
`endif
    expect_v("pre_sweep_busy", SBUSY, 0);
    cyc();
    clear = 1'b0;
    expect_v("sw1_busy", SBUSY, 1);
    expect_v("sw1_done", SDONE, 0);
`ifndef REGFILE_R0_ZERO_EN
    expect_v("sw1_r0", SA, 8'h01);
`endif
    cyc();
    expect_v("sw2_busy", SBUSY, 1);
    expect_v("sw2_r0", SA, 8'h00);
    expect_v("sw2_r3", SB, 8'h04);
    cyc();
    expect_v("sw3_busy", SBUSY, 1);
    expect_v("sw3_done", SDONE, 0);
    expect_v("sw3_r3", SB, 8'h04);
    cyc();
    expect_v("sw4_busy", SBUSY, 1);
    expect_v("sw4_done", SDONE, 1);
    expect_v("sw4_r3", SB, 8'h04);
    cyc();
    expect_v("post_busy", SBUSY, 0);
    expect_v("post_done", SDONE, 0);
    expect_v("post_r3", SB, 8'h00);
    regA = 2'd1; regB = 2'd2;
    cyc();
    expect_v("post_r1", SA, 8'h00);
    expect_v("post_r2", SB, 8'h00);

    // write blocked during sweep
    cyc();
    wr(2'd2, 8'h33);
    clear = 1'b1; regA = 2'd2;
    cyc();
    clear = 1'b0;
    cyc();
    RFWrite = 1'b1; regW = 2'd2; dataW = 8'hFF;
    expect_v("blk_nobyp", SA, 8'h33);
    cyc();
    RFWrite = 1'b0; dataW = 8'h00;
    expect_v("blk_nowrite", SA, 8'h33);
    cyc();
    cyc();
    expect_v("blk_after", SA, 8'h00);
    expect_v("blk_idle", SBUSY, 0);

    // reset mid-sweep
    cyc();
    wr(2'd3, 8'h55);
    clear = 1'b1; regB = 2'd3;
    cyc();
    clear = 1'b0;
    expect_v("rs1_busy", SBUSY, 1);
    expect_v("rs1_r3", SB, 8'h55);
    cyc();
    #2 resetn = 1'b0;
    expect_v("rs_busy_async", SBUSY, 0);
    expect_v("rs_done", SDONE, 0);
    expect_v("rs_r3", SB, 8'h00);
    cyc();
    resetn = 1'b1;
    cyc();
    expect_v("rs_stay_idle", SBUSY, 0);
    expect_v("rs_no_done", SDONE, 0);

    // entry 0 write
    cyc();
    RFWrite = 1'b1; regW = 2'd0; dataW = 8'h9A; regA = 2'd0;
`ifdef REGFILE_R0_ZERO_EN
    expect_v("r0_same_cycle", SA, 8'h00);
`else
    expect_v("r0_same_cycle", SA, 8'h9A);
`endif
    cyc();
    RFWrite = 1'b0; dataW = 8'h00;
`ifdef REGFILE_R0_ZERO_EN
    expect_v("r0_after", SA, 8'h00);
`else
    expect_v("r0_after", SA, 8'h9A);
`endif

    // wide instance: 16-bit data, 8-entry sweep
    cyc();
    w_RFWrite = 1'b1; w_regW = 3'd5; w_dataW = 16'hBEEF;
    cyc();
    w_regW = 3'd7; w_dataW = 16'h1234;
    cyc();
    w_RFWrite = 1'b0; w_regA = 3'd5; w_regB = 3'd7;
    expect_v("w_r5", WA, 16'hBEEF);
    expect_v("w_r7", WB, 16'h1234);
    w_clear = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      w_clear = 1'b0;
      expect_v("w_busy", WBUSY, 1);
      expect_v("w_done", WDONE, (k == 7) ? 32'd1 : 32'd0);
    end
    cyc();
    expect_v("w_busy_end", WBUSY, 0);
    expect_v("w_r5_clr", WA, 0);
    expect_v("w_r7_clr", WB, 0);

    cyc();
    cyc();
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
